// File: rtl/euler_engine_if.sv
// Host-facing bus bundle for euler_engine: control registers, input-buffer write port
// and output-buffer read port. The host drives through master; the engine sits on slave.
interface euler_engine_if;
  logic [7:0]  data_control_address;
  logic        data_control_read;
  logic        data_control_write;
  logic [31:0] data_control_writedata;
  logic [31:0] data_control_readdata;
  logic        data_in_write;
  logic [7:0]  data_in_address;
  logic [31:0] data_in_writedata;
  logic [7:0]  data_out_address;
  logic [31:0] data_out_readdata;

  modport master (
    output data_control_address, data_control_read, data_control_write,
    output data_control_writedata, data_in_write, data_in_address, data_in_writedata,
    output data_out_address,
    input  data_control_readdata, data_out_readdata
  );

  modport slave (
    input  data_control_address, data_control_read, data_control_write,
    input  data_control_writedata, data_in_write, data_in_address, data_in_writedata,
    input  data_out_address,
    output data_control_readdata, data_out_readdata
  );
endinterface

// File: rtl/euler_engine.sv
// Forward-Euler integrator x[i+1] = x[i] + h*f[i] (signed Q16.16) over 256-word buffers.
// Define EULER_SAT_EN to saturate the accumulation and expose a sticky sat flag (status bit3).
module euler_engine #(
  parameter int DEPTH = 256,
  parameter int FRAC  = 16
) (
  input logic           clk_clk,
  input logic           reset_reset_n,
  euler_engine_if.slave bus
);
  localparam logic [31:0] ID_VALUE = 32'h4555_4C31;

  typedef enum logic [2:0] {IDLE, RD, MUL, ACC, FIN} state_t;

  state_t             state_reg;
  logic [8:0]         count_reg;
  logic signed [31:0] step_reg;
  logic signed [31:0] x0_reg;
  logic signed [31:0] x_reg;
  logic signed [31:0] xfinal_reg;
  logic signed [31:0] x_next;
  logic signed [31:0] in_rdata;
  logic signed [63:0] p_reg;
  logic [31:0]        cycles_reg;
  logic [31:0]        cyc_reg;
  logic [7:0]         i_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;
  logic               sat_flag;
  logic               ctrl_wr;
  logic               cfg_wr;
  logic               start;
  logic               last_sample;

  logic [31:0] in_mem  [DEPTH];
  logic [31:0] out_mem [DEPTH];

  assign ctrl_wr     = bus.data_control_write && (bus.data_control_address == 8'h00);
  assign cfg_wr      = bus.data_control_write && !busy_reg;
  assign start       = ctrl_wr && bus.data_control_writedata[0] && !busy_reg;
  assign last_sample = ({1'b0, i_reg} == (count_reg - 9'd1));

`ifdef EULER_SAT_EN
  logic signed [63:0] acc_wide;
  logic               sat_hit;
  logic               sat_reg;

  always_comb begin
    acc_wide = 64'(x_reg) + (p_reg >>> FRAC);
    sat_hit  = 1'b0;
    x_next   = acc_wide[31:0];
    if (acc_wide > 64'sh0000_0000_7FFF_FFFF) begin
      x_next  = 32'h7FFF_FFFF;
      sat_hit = 1'b1;
    end else if (acc_wide < 64'shFFFF_FFFF_8000_0000) begin
      x_next  = 32'h8000_0000;
      sat_hit = 1'b1;
    end
  end

  // A saturation in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sat_reg <= 1'b0;
    end else begin
      if (ctrl_wr && bus.data_control_writedata[2]) sat_reg <= 1'b0;
      if (state_reg == ACC && sat_hit) sat_reg <= 1'b1;
    end
  end

  assign sat_flag = sat_reg;
`else
  assign x_next   = x_reg + 32'(p_reg >>> FRAC);
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk_clk) begin
    if (bus.data_in_write && !busy_reg) in_mem[bus.data_in_address] <= bus.data_in_writedata;
    in_rdata <= in_mem[i_reg];
  end

  always_ff @(posedge clk_clk) begin
    if (state_reg == ACC) out_mem[i_reg] <= x_next;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) bus.data_out_readdata <= 32'd0;
    else                bus.data_out_readdata <= out_mem[bus.data_out_address];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg  <= IDLE;
      count_reg  <= 9'd0;
      step_reg   <= 32'sd0;
      x0_reg     <= 32'sd0;
      x_reg      <= 32'sd0;
      xfinal_reg <= 32'sd0;
      p_reg      <= 64'sd0;
      cycles_reg <= 32'd0;
      cyc_reg    <= 32'd0;
      i_reg      <= 8'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (bus.data_control_address)
          8'h01:   count_reg <= (bus.data_control_writedata > 32'd256) ? 9'd256
                                                                      : bus.data_control_writedata[8:0];
          8'h02:   step_reg  <= bus.data_control_writedata;
          8'h03:   x0_reg    <= bus.data_control_writedata;
          default: ;
        endcase
      end
      if (ctrl_wr && bus.data_control_writedata[1]) done_reg <= 1'b0;
      if (ctrl_wr && bus.data_control_writedata[2]) err_reg  <= 1'b0;
      if (bus.data_in_write && busy_reg)            err_reg  <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (start) begin
            i_reg     <= 8'd0;
            x_reg     <= x0_reg;
            cyc_reg   <= 32'd0;
            busy_reg  <= 1'b1;
            state_reg <= (count_reg == 9'd0) ? FIN : RD;
          end
        end
        RD: begin
          cyc_reg   <= cyc_reg + 32'd1;
          state_reg <= MUL;
        end
        MUL: begin
          p_reg     <= step_reg * in_rdata;
          cyc_reg   <= cyc_reg + 32'd1;
          state_reg <= ACC;
        end
        ACC: begin
          x_reg     <= x_next;
          i_reg     <= i_reg + 8'd1;
          cyc_reg   <= cyc_reg + 32'd1;
          state_reg <= last_sample ? FIN : RD;
        end
        FIN: begin
          xfinal_reg <= x_reg;
          cycles_reg <= cyc_reg;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bus.data_control_readdata <= 32'd0;
    end else if (bus.data_control_read) begin
      case (bus.data_control_address)
        8'h00:   bus.data_control_readdata <= {28'd0, sat_flag, err_reg, done_reg, busy_reg};
        8'h01:   bus.data_control_readdata <= {23'd0, count_reg};
        8'h02:   bus.data_control_readdata <= step_reg;
        8'h03:   bus.data_control_readdata <= x0_reg;
        8'h04:   bus.data_control_readdata <= xfinal_reg;
        8'h05:   bus.data_control_readdata <= cycles_reg;
        8'h06:   bus.data_control_readdata <= ID_VALUE;
        default: bus.data_control_readdata <= 32'd0;
      endcase
    end
  end
endmodule

// File: doc/euler_engine.md
# euler_engine

FPGA-side fabric block that terminates the three exported HPS ports of the `memory_io` system: the `data_control` register port, the `data_in` input-buffer write port and the `data_out` output-buffer read port. The host fills a 256-word input buffer with a forcing signal f[i] and programs the step size and initial state. It then starts a run, and the block integrates x[i+1] = x[i] + h·f[i] (forward Euler, signed Q16.16) into a 256-word output buffer that the host reads back.

## Interface
Parameters:
- `DEPTH`, 256: buffer depth in words; fixed by the 8-bit port addresses.
- `FRAC`, 16: fractional bits of the Q format.

Ports:
- `clk_clk` in 1: single clock.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `data_control_address` in 8: register word address.
- `data_control_read` in 1: register read strobe.
- `data_control_write` in 1: register write strobe.
- `data_control_writedata` in 32: register write data.
- `data_control_readdata` out 32: register read data, read latency 1.
- `data_in_write` in 1: input-buffer write strobe.
- `data_in_address` in 8: input-buffer word address.
- `data_in_writedata` in 32: f[i], signed Q16.16.
- `data_out_address` in 8: output-buffer word address.
- `data_out_readdata` out 32: output-buffer data, latency 1, no strobe.

## Operation
Register map (word addresses):
- 0x00 CTRL/STATUS
  - Write: bit0 = start; bit1 = clear done; bit2 = clear err.
  - Read: bit0 = busy; bit1 = done; bit2 = err.
- 0x01 COUNT: 9 bits. Values above 256 clamp to 256.
- 0x02 STEP h: signed Q16.16.
- 0x03 X0: signed Q16.16.
- 0x04 XFINAL: read-only.
- 0x05 CYCLES: read-only.
- 0x06 ID: read-only, constant 0x4555_4C31.
- All other addresses read 0. Writes to them are ignored.

FSM:
- IDLE: on start, go to RD and load i=0, x=X0, cyc=0. If COUNT=0, go directly to FIN instead.
- RD: present input-buffer address i.
- MUL: input data is valid; register p = h·f[i] as a signed 64-bit product.
- ACC: compute x ← x + (p >>> FRAC) (arithmetic shift, rounds toward −∞); write x to output buffer [i]; i++.
  - If i+1 = COUNT, go to FIN.
  - Otherwise go to RD.
- FIN: XFINAL ← x, CYCLES ← cyc, done ← 1, busy ← 0; go to IDLE.
- cyc increments on every RD, MUL and ACC cycle.

Boundary rules:
- Start while busy: ignored.
- Writes to COUNT, STEP or X0 while busy: ignored.
- `data_in_write` while busy: dropped, and err is set (sticky).
- One CTRL write containing both clear done and start: done is cleared first, then the run starts.
- Output-buffer reads while busy return current contents. Partially written results are visible.
- Input-buffer and output-buffer contents are not reset.
- i wraps are impossible: COUNT ≤ 256 and an 8-bit index is compared against COUNT−1.

## Timing
Reset values:
- `data_control_readdata` = 0, `data_out_readdata` = 0.
- All registers 0, FSM in IDLE, busy/done/err = 0.

Latencies:
- Register read with `data_control_read` in cycle t: data in cycle t+1. Readdata holds its value otherwise.
- `data_out_address` in cycle t: `data_out_readdata` in cycle t+1.

Run timing:
- A start written in cycle t makes busy readable as 1 from cycle t+1.
- Each sample takes exactly 3 cycles, so a run of N samples takes 3N cycles in RD/MUL/ACC.
- FIN occupies cycle t+1+3N. done reads 1 from cycle t+2+3N. CYCLES = 3N.
- COUNT=0: FIN at t+1, CYCLES = 0, XFINAL = X0, no buffer writes.

Reset mid-run:
- FSM returns to IDLE immediately.
- Status and registers return to 0.
- Buffer contents already written remain.

## Configuration
- `EULER_SAT_EN` defined: the ACC addition saturates to 0x7FFF_FFFF / 0x8000_0000. Every saturation event sets status bit3 (sat, sticky). Bit3 is cleared by writing CTRL bit2.
- `EULER_SAT_EN` undefined: the addition wraps modulo 2^32, and status bit3 reads 0.

## Test plan
- Reset, then read 0x06 → 0x4555_4C31. STATUS → 0. `data_out_readdata` → 0.
- f[0..3] = 0x0001_0000, h = 0x0000_8000, X0 = 0, COUNT = 4, start → out[0..3] = 0x8000, 0x1_0000, 0x1_8000, 0x2_0000; XFINAL = 0x2_0000; CYCLES = 12; done asserted 14 cycles after the start write.
- COUNT = 0, X0 = 0x1234_5678, start → done at t+2, XFINAL = 0x1234_5678, CYCLES = 0, output buffer unchanged.
- During a COUNT = 256 run: write `data_in`, write COUNT = 5, write start → err = 1, COUNT unchanged, run completes with CYCLES = 768.
- f = 0x7FFF_0000, h = 0x0001_0000, X0 = 0x7FFF_0000, COUNT = 1:
  - With `EULER_SAT_EN` → XFINAL = 0x7FFF_FFFF, sat = 1.
  - Without → XFINAL = 0xFFFE_0000.
- Assert `reset_reset_n` low in the middle of a run → busy = 0 and FSM in IDLE; a new start then completes normally.
